msi_cfg_sequencer: RTL

//   Upstream feeder for the FM tuner SPI master. Builds the 24-bit tuner register words:
//   an init table after reset, then one synthesizer word per frequency change.

---
 rtl/msi_cfg_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/msi_cfg_sequencer.sv
// Feeds 24-bit FM tuner register words into the SPI master's write FIFO:
// an init table after reset or cfg_start, then one synthesizer word per frequency change.
module msi_cfg_sequencer #(
    parameter bit          AUTO_INIT = 1'b1,
    parameter logic [23:0] INIT_W0   = 24'h0C3420,
    parameter logic [23:0] INIT_W1   = 24'h000051,
    parameter logic [23:0] INIT_W2   = 24'h014003,
    parameter logic [23:0] INIT_W3   = 24'h000006,
    parameter logic [3:0]  FREQ_ADDR = 4'h2
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        cfg_start,
    input  logic        freq_req,
    input  logic [7:0]  freq_int,
    input  logic [11:0] freq_frac,
    input  logic        fifo_full,
    output logic [23:0] spi_word,
    output logic        spi_wr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, INIT, FREQ, GAP, FIN} state_t;

    state_t      state, state_next;
    logic [2:0]  idx;
    logic        pend_init, pend_freq;
    logic [7:0]  int_s;
    logic [11:0] frac_s;
    logic [23:0] init_word;
    logic        push_init, push_freq, enter_init, enter_freq, fin;

    always_comb begin
        case (idx[1:0])
            2'd0:    init_word = INIT_W0;
            2'd1:    init_word = INIT_W1;
            2'd2:    init_word = INIT_W2;
            default: init_word = INIT_W3;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        push_init  = 1'b0;
        push_freq  = 1'b0;
        enter_init = 1'b0;
        enter_freq = 1'b0;
        fin        = 1'b0;
        case (state)
            IDLE: begin
                if (pend_init) begin
                    state_next = INIT;
                    enter_init = 1'b1;
                end else if (pend_freq) begin
                    state_next = FREQ;
                    enter_freq = 1'b1;
                end
            end
            INIT: begin
                if (!fifo_full) begin
                    push_init  = 1'b1;
                    state_next = GAP;
                end
            end
            // The FIFO full flag lags a write by one cycle, so pushes stay two cycles apart.
            GAP: begin
                if (idx == 3'd4) begin
                    state_next = FREQ;
                    enter_freq = 1'b1;
                end else begin
                    state_next = INIT;
                end
            end
            FREQ: begin
                if (!fifo_full) begin
                    push_freq  = 1'b1;
                    state_next = FIN;
                end
            end
            FIN: begin
                fin        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            idx       <= '0;
            pend_init <= AUTO_INIT;
            pend_freq <= 1'b0;
            int_s     <= '0;
            frac_s    <= '0;
            spi_word  <= '0;
            spi_wr    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state  <= state_next;
            spi_wr <= push_init | push_freq;
            done   <= fin;

            if (push_init) begin
                spi_word <= init_word;
            end else if (push_freq) begin
                spi_word <= {frac_s, int_s, FREQ_ADDR};
            end

            if (enter_init) begin
                idx <= '0;
            end else if (push_init) begin
                idx <= idx + 3'd1;
            end

            if (enter_freq) begin
                int_s  <= freq_int;
                frac_s <= freq_frac;
            end

            // Clearing on INIT entry lets a cfg_start seen later in the sequence force a re-run.
            if (cfg_start) begin
                pend_init <= 1'b1;
            end else if (enter_init) begin
                pend_init <= 1'b0;
            end

            // A freq_req on the entry edge is already covered by the values latched there.
            if (enter_freq) begin
                pend_freq <= 1'b0;
            end else if (freq_req || (push_init && idx == 3'd3)) begin
                pend_freq <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
